// File: rtl/and_reduce_pipe_if.sv
// Handshake and status bundle for and_reduce_pipe: operand input side,
// pipelined result side, combinational result and the hit counter.
interface and_reduce_pipe_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] in_data;
  logic [1:0]       mode;
  logic             in_valid;
  logic             in_ready;
  logic             comb_out;
  logic             out_data;
  logic             out_valid;
  logic             out_ready;
  logic             clear;
  logic [CNT_W-1:0] hit_count;

  modport master (
    output in_data, mode, in_valid, out_ready, clear,
    input  in_ready, comb_out, out_data, out_valid, hit_count
  );

  modport slave (
    input  in_data, mode, in_valid, out_ready, clear,
    output in_ready, comb_out, out_data, out_valid, hit_count
  );
endinterface

// File: rtl/and_reduce_pipe.sv
// Reduces a WIDTH-bit vector with AND/OR/XOR/NAND, both combinationally and
// through a DEPTH-stage elastic valid/ready pipeline, counting delivered 1s.
module and_reduce_pipe #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  and_reduce_pipe_if.slave bus
);

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  localparam logic [CNT_W-1:0] HIT_MAX = '1;

  function automatic logic reduce_op(input logic [WIDTH-1:0] d, input op_e op);
    logic r;
    r = 1'b0;
    case (op)
      OP_AND:  r = &d;
      OP_OR:   r = |d;
      OP_XOR:  r = ^d;
      OP_NAND: r = ~&d;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  logic             comb_result;
  logic             in_fire;
  logic             out_fire;
  logic [DEPTH-1:0] stage_valid;
  logic [DEPTH-1:0] stage_data;
  logic [DEPTH-1:0] src_valid;
  logic [DEPTH-1:0] src_data;
  logic [DEPTH-1:0] advance;
  logic [CNT_W-1:0] hit_count;

  // Mode is applied here, so a result captured into S0 is frozen from then on.
  assign comb_result  = reduce_op(bus.in_data, op_e'(bus.mode));
  assign bus.comb_out = comb_result;

  // A stage may advance when it, or any stage between it and the tail, is a
  // bubble, or when the tail is being drained this cycle.
  always_comb begin
    logic bubble;
    // NOTE: blocking assignments in combinational logic; bubble is a running
    // temporary, so each iteration must see the previous iteration's value.
    bubble  = bus.out_ready;
    advance = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      bubble     = bubble || !stage_valid[k];
      advance[k] = bubble;
    end
  end

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    src_valid    = '0;
    src_data     = '0;
    src_valid[0] = in_fire;
    src_data[0]  = comb_result;
    for (int k = 1; k < DEPTH; k++) begin
      src_valid[k] = stage_valid[k-1];
      src_data[k]  = stage_data[k-1];
    end
  end

  assign bus.in_ready  = rst_n && advance[0];
  assign in_fire       = bus.in_valid && bus.in_ready;
  assign bus.out_valid = stage_valid[DEPTH-1];
  assign bus.out_data  = stage_data[DEPTH-1];
  assign out_fire      = stage_valid[DEPTH-1] && bus.out_ready;

  // NOTE: the stage registers are small and reset explicitly, so reset
  // discards in-flight results and empty stages never carry X downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid <= '0;
      stage_data  <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (advance[k]) begin
          stage_valid[k] <= src_valid[k];
          stage_data[k]  <= src_valid[k] && src_data[k];
        end
      end
    end
  end

  // Clear takes priority over a coincident delivery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count <= '0;
    end else if (bus.clear) begin
      hit_count <= '0;
    end else if (out_fire && stage_data[DEPTH-1] && hit_count != HIT_MAX) begin
      hit_count <= hit_count + CNT_W'(1);
    end
  end

  assign bus.hit_count = hit_count;

endmodule

// File: tb/tb_and_reduce_pipe.sv
// Scoreboard bench for and_reduce_pipe: accepted operands are reduced by a
// counting model and queued; a monitor pops and compares each delivery.
module tb_and_reduce_pipe;
  localparam int WIDTH   = 4;
  localparam int DEPTH   = 2;
  localparam int CNT_W   = 2;
  localparam int HIT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  and_reduce_pipe_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  and_reduce_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  bit exp_q[$];
  int model_hit = 0;
  int edge_n;
  int first_seen;
  int acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: reduction defined by the number of ones in the operand.
  function automatic bit ref_reduce(input logic [WIDTH-1:0] d, input logic [1:0] m);
    int ones;
    ones = $countones(d);
    case (m)
      2'd0:    return ones == WIDTH;
      2'd1:    return ones != 0;
      2'd2:    return (ones % 2) == 1;
      default: return ones != WIDTH;
    endcase
  endfunction

  // Acceptance tap: expected result queued when the input transfer happens.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.in_valid && bus.in_ready)
      exp_q.push_back(ref_reduce(bus.in_data, bus.mode));
  end

  // Monitor: compares deliveries and tracks the expected hit counter.
  always @(negedge clk) begin : monitor
    bit e;
    bit fire;
    e    = 1'b0;
    fire = 1'b0;
    if (rst_n !== 1'b1) begin
      exp_q.delete();
      model_hit = 0;
      check("reset_in_ready", 32'(bus.in_ready), 0);
    end else begin
      check("hit_count", 32'(bus.hit_count), 32'(model_hit));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_output", 32'(bus.out_valid), 0);
        end else begin
          e    = exp_q.pop_front();
          fire = 1'b1;
          check("out_data", 32'(bus.out_data), 32'(e));
        end
      end else if (!bus.out_valid) begin
        check("idle_out_data", 32'(bus.out_data), 0);
      end
      if (bus.clear)
        model_hit = 0;
      else if (fire && e && model_hit < HIT_MAX)
        model_hit++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_track();
    step();
    edge_n++;
    if (bus.out_valid && first_seen < 0) first_seen = edge_n;
  endtask

  task automatic drive(input logic [WIDTH-1:0] d, input logic [1:0] m, input logic v);
    bus.in_data  = d;
    bus.mode     = m;
    bus.in_valid = v;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
  endtask

  task automatic wait_drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (exp_q.size() == 0 && !bus.out_valid) break;
      step();
    end
    check("drain_queue", 32'(exp_q.size()), 0);
    check("drain_out_valid", 32'(bus.out_valid), 0);
  endtask

  task automatic fill(output int accepted);
    bus.out_ready = 1'b0;
    accepted = 0;
    for (int c = 0; c < 20; c++) begin
      drive(WIDTH'($urandom), 2'($urandom), 1'b1);
      #1;
      if (!bus.in_ready) break;
      accepted++;
      step();
    end
  endtask

  logic [WIDTH-1:0] stream_v [4];
  bit               mode_exp [4];

  initial begin
    stream_v = '{4'b1111, 4'b0111, 4'b1010, 4'b1111};
    mode_exp = '{1'b0, 1'b1, 1'b0, 1'b1};
    rst_n = 1'b0;
    drive('0, 2'b00, 1'b0);
    bus.out_ready = 1'b0;
    bus.clear     = 1'b0;

    // Reset values with random inputs
    for (int i = 0; i < 3; i++) begin
      drive(WIDTH'($urandom), 2'($urandom), 1'($urandom));
      bus.out_ready = 1'($urandom);
      step();
      check("rst_out_valid", 32'(bus.out_valid), 0);
      check("rst_out_data", 32'(bus.out_data), 0);
      check("rst_hit_count", 32'(bus.hit_count), 0);
      check("rst_in_ready", 32'(bus.in_ready), 0);
    end
    drive(4'b1111, 2'b00, 1'b0);
    #1;
    check("rst_comb_out", 32'(bus.comb_out), 1);

    // Streaming latency and data sequence 1,0,0,1
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    edge_n = 0;
    first_seen = -1;
    for (int i = 0; i < 4; i++) begin
      drive(stream_v[i], 2'b00, 1'b1);
      step_track();
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 6; i++) step_track();
    check("stream_latency", 32'(first_seen), 32'(DEPTH));
    wait_drain();
    check("stream_hits", 32'(bus.hit_count), 2);

    // Mode coverage on 0110
    bus.out_ready = 1'b1;
    for (int m = 0; m < 4; m++) begin
      drive(4'b0110, 2'(m), 1'b1);
      #1;
      check("mode_comb", 32'(bus.comb_out), 32'(mode_exp[m]));
      step();
    end
    wait_drain();

    // Mode change after acceptance must not affect the result
    pulse_clear();
    drive(4'b1111, 2'b00, 1'b1);
    step();
    drive(4'b1111, 2'b11, 1'b0);
    #1;
    check("inflight_comb_now", 32'(bus.comb_out), 0);
    wait_drain();
    check("inflight_hits", 32'(bus.hit_count), 1);

    // Backpressure: exactly DEPTH buffered, ready returns with out_ready
    fill(acc);
    check("bp_buffered", 32'(acc), 32'(DEPTH));
    check("bp_in_ready_low", 32'(bus.in_ready), 0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("bp_in_ready_back", 32'(bus.in_ready), 1);
    wait_drain();

    // Saturation at 2^CNT_W-1, then clear beating a coincident hit
    pulse_clear();
    for (int i = 0; i < 5; i++) begin
      drive(4'b1111, 2'b00, 1'b1);
      step();
    end
    wait_drain();
    check("sat_hits", 32'(bus.hit_count), 3);
    pulse_clear();
    check("cleared", 32'(bus.hit_count), 0);
    drive(4'b1111, 2'b00, 1'b1);
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (bus.out_valid) break;
      step();
    end
    check("stall_out_valid", 32'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    pulse_clear();
    check("clear_wins", 32'(bus.hit_count), 0);
    wait_drain();

    // Asynchronous reset with a full pipeline
    drive(4'b1111, 2'b00, 1'b1);
    step();
    fill(acc);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", 32'(bus.out_valid), 0);
    check("async_out_data", 32'(bus.out_data), 0);
    check("async_in_ready", 32'(bus.in_ready), 0);
    check("async_hit_count", 32'(bus.hit_count), 0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    edge_n = 0;
    first_seen = -1;
    for (int i = 0; i < 6; i++) step_track();
    check("no_stale_results", 32'(first_seen), 32'(-1));
    edge_n = 0;
    first_seen = -1;
    drive(4'b0001, 2'b01, 1'b1);
    step_track();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step_track();
    check("post_reset_latency", 32'(first_seen), 32'(DEPTH));
    wait_drain();

    // Randomised traffic with random backpressure and occasional clear
    for (int i = 0; i < 300; i++) begin
      drive(WIDTH'($urandom), 2'($urandom), 1'($urandom_range(0, 3) != 0));
      bus.out_ready = 1'($urandom_range(0, 3) != 0);
      bus.clear     = 1'($urandom_range(0, 31) == 0);
      #1;
      check("rand_comb", 32'(bus.comb_out), 32'(ref_reduce(bus.in_data, bus.mode)));
      step();
    end
    bus.clear = 1'b0;
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
